// File: rtl/uart_rx_mv.sv
// Majority-vote UART receiver with 16x oversampling.
// Decodes 7/8 data bits, optional even/odd parity and 1/2 stop bits, filters
// false starts, flags breaks, and presents each frame through a valid/ready
// holding register with per-frame error flags.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   tick           16x baud enable, one clk cycle wide
//   rx             asynchronous serial line, idle high
//   d_num          0 = 7 data bits, 1 = 8 data bits
//   s_num          0 = 1 stop bit, 1 = 2 stop bits
//   par            00/11 none, 01 even, 10 odd
//   rx_ready       consumer accepts the held frame
//   data_out       held data byte (bit 7 = 0 in 7-bit mode)
//   rx_valid       held frame available
//   parity_error   parity mismatch for the held frame
//   frame_error    a stop bit sampled low for the held frame
//   break_det      held frame is a break
//   overrun        one-cycle pulse when a completed frame is dropped
//   rx_busy        receiver is not idle
module uart_rx_mv #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rx,
    input  logic       d_num,
    input  logic       s_num,
    input  logic [1:0] par,
    input  logic       rx_ready,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       break_det,
    output logic       overrun,
    output logic       rx_busy
);

    localparam logic [3:0] LastIdx = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] Vote0Idx = 4'd7;
    localparam logic [3:0] Vote1Idx = 4'd8;
    localparam logic [3:0] MidIdx = 4'd9;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    state_e state_q, state_d;

    logic       rx_meta_q, rx_s_q;
    logic [3:0] cnt_q;
    logic [3:0] idx;
    logic       v7_q, v8_q;
    logic       maj;
    logic [2:0] bit_cnt_q;
    logic [7:0] data_q;
    logic       pbit_q;
    logic       ferr_q;
    logic       stop_cnt_q;
    logic       d8_q, s2_q, pen_q, podd_q;

    logic       mid_tick, end_tick;
    logic       last_data, last_stop;
    logic       ferr_fin, perr_fin, brk_fin;
    logic       frame_done;

    logic [7:0] data_out_q;
    logic       valid_q, perr_q, ferr_out_q, brk_q, overrun_q;

    // cnt_q holds the index of the last tick seen, so idx is the index of the current one.
    always_comb begin
        idx       = cnt_q + 4'd1;
        maj       = (v7_q & v8_q) | (v7_q & rx_s_q) | (v8_q & rx_s_q);
        mid_tick  = tick && (idx == MidIdx);
        end_tick  = tick && (idx == LastIdx);
        last_data = (bit_cnt_q == (d8_q ? 3'd7 : 3'd6));
        last_stop = !s2_q || stop_cnt_q;
        // The final stop bit is voted in the completing cycle, so fold it in here.
        ferr_fin  = ferr_q | ~maj;
        perr_fin  = pen_q && ((^data_q ^ pbit_q) != podd_q);
        brk_fin   = ferr_fin && (data_q == 8'h00) && (!pen_q || !pbit_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (tick && !rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (mid_tick && maj) begin
                    state_d = StIdle;
                end else if (end_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (end_tick && last_data) state_d = pen_q ? StParity : StStop;
            end
            StParity: begin
                if (end_tick) state_d = StStop;
            end
            StStop: begin
                if (mid_tick && last_stop) state_d = brk_fin ? StBrkWait : StIdle;
            end
            StBrkWait: begin
                if (tick && rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        rx_busy    = (state_q != StIdle);
        frame_done = (state_q == StStop) && mid_tick && last_stop;
    end

    // Synchronizer, bit timing and frame assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= 4'd0;
            v7_q       <= 1'b0;
            v8_q       <= 1'b0;
            bit_cnt_q  <= 3'd0;
            data_q     <= 8'h00;
            pbit_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_cnt_q <= 1'b0;
            d8_q       <= 1'b0;
            s2_q       <= 1'b0;
            pen_q      <= 1'b0;
            podd_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            if (tick) begin
                if (state_q == StIdle) begin
                    if (!rx_s_q) begin
                        // Frame configuration is frozen here for the whole frame.
                        cnt_q      <= 4'd0;
                        d8_q       <= d_num;
                        s2_q       <= s_num;
                        pen_q      <= (par == 2'b01) || (par == 2'b10);
                        podd_q     <= (par == 2'b10);
                        data_q     <= 8'h00;
                        bit_cnt_q  <= 3'd0;
                        stop_cnt_q <= 1'b0;
                        ferr_q     <= 1'b0;
                        pbit_q     <= 1'b0;
                    end
                end else begin
                    cnt_q <= idx;
                    if (idx == Vote0Idx) v7_q <= rx_s_q;
                    if (idx == Vote1Idx) v8_q <= rx_s_q;
                    if (idx == MidIdx) begin
                        case (state_q)
                            StData:   data_q[bit_cnt_q] <= maj;
                            StParity: pbit_q <= maj;
                            StStop:   if (!maj) ferr_q <= 1'b1;
                            default:  ;
                        endcase
                    end
                    if (idx == LastIdx) begin
                        case (state_q)
                            StData:  bit_cnt_q <= bit_cnt_q + 3'd1;
                            StStop:  stop_cnt_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Holding register and handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (frame_done) begin
                if (!valid_q || rx_ready) begin
                    data_out_q <= data_q;
                    perr_q     <= perr_fin;
                    ferr_out_q <= ferr_fin;
                    brk_q      <= brk_fin;
                    valid_q    <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out     = data_out_q;
    assign rx_valid     = valid_q;
    assign parity_error = perr_q;
    assign frame_error  = ferr_out_q;
    assign break_det    = brk_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_mv.sv
module tb_uart_rx_mv;

    localparam int TickDiv = 4;
    localparam int Os = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic       d_num = 1'b1;
    logic       s_num = 1'b0;
    logic [1:0] par = 2'b00;
    logic       rx_ready = 1'b0;
    logic [7:0] data_out;
    logic       rx_valid, parity_error, frame_error, break_det, overrun, rx_busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ovr_cnt = 0;
    int rise_cnt = 0;
    int tdiv = 0;
    logic prev_valid = 1'b0;
    logic [10:0] got_q[$];

    uart_rx_mv #(.OVERSAMPLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .rx           (rx),
        .d_num        (d_num),
        .s_num        (s_num),
        .par          (par),
        .rx_ready     (rx_ready),
        .data_out     (data_out),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .break_det    (break_det),
        .overrun      (overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv = (tdiv + 1) % TickDiv;
        tick = (tdiv == 0);
    end

    // Records every accepted frame, overrun pulses and rx_valid rising edges.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1)
            got_q.push_back({data_out, parity_error, frame_error, break_det});
        if (overrun === 1'b1) ovr_cnt++;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cnt++;
        prev_valid = rx_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt,
                 total_cnt);
        $fatal(1);
    end

    function automatic logic good_par(input logic [7:0] data, input logic d8,
                                      input logic [1:0] p);
        logic [7:0] d = d8 ? data : {1'b0, data[6:0]};
        logic odd_ones = ($countones(d) % 2) == 1;
        return (p == 2'b10) ? !odd_ones : odd_ones;
    endfunction

    // Expected {data_out, parity_error, frame_error, break_det} for the bits put on the line.
    function automatic logic [10:0] model(input logic [7:0] data, input logic d8,
                                          input logic [1:0] p, input logic s2,
                                          input logic pbit, input logic st0, input logic st1);
        logic [7:0] d = d8 ? data : {1'b0, data[6:0]};
        int ones = $countones(d) + int'(pbit);
        logic pen = (p == 2'b01) || (p == 2'b10);
        logic pe = pen && ((ones % 2) != ((p == 2'b10) ? 1 : 0));
        logic fe = !st0 || (s2 && !st1);
        logic bd = fe && (d == 8'h00) && (!pen || !pbit);
        return {d, pe, fe, bd};
    endfunction

    function automatic logic [11:0] pop_got();
        if (got_q.size() == 0) return 12'h000;
        return {1'b1, got_q.pop_front()};
    endfunction

    task automatic align();
        do @(posedge clk); while (tick !== 1'b1);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) align();
    endtask

    task automatic send_bit(input logic b);
        align();
        #1 rx = b;
        wait_ticks(Os - 1);
    endtask

    task automatic send_head(input logic [7:0] data, input logic d8, input logic [1:0] p,
                             input logic s2, input logic pbit);
        align();
        #1;
        d_num = d8;
        s_num = s2;
        par = p;
        rx = 1'b0;
        wait_ticks(Os - 1);
        for (int i = 0; i < (d8 ? 8 : 7); i++) send_bit(data[i]);
        if (p == 2'b01 || p == 2'b10) send_bit(pbit);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic d8, input logic [1:0] p,
                              input logic s2, input logic pbit, input logic st0,
                              input logic st1);
        send_head(data, d8, p, s2, pbit);
        send_bit(st0);
        if (s2) send_bit(st1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out);
        else pass_cnt++;
        total_cnt++;
        if ({parity_error, frame_error, break_det} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {parity_error, frame_error, break_det});
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun);
        else pass_cnt++;
        total_cnt++;
        if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy);
        else pass_cnt++;
        reset = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_8n1_latency();
        rx_ready = 1'b1;
        got_q.delete();
        send_head(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0);
        align();
        #1 rx = 1'b1;
        wait_ticks(9);
        #1;
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL lat_early: got %b want 0", rx_valid);
        else pass_cnt++;
        repeat (TickDiv - 1) @(posedge clk);
        #1;
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL lat_before_tick9: got %b want 0", rx_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({rx_valid, data_out, parity_error, frame_error, break_det} !== {1'b1, 8'hA5, 3'b000})
            $display("FAIL lat_rise: got v=%b d=%h f=%b want v=1 d=a5 f=000", rx_valid, data_out,
                     {parity_error, frame_error, break_det});
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL lat_pulse: got %b want 0", rx_valid);
        else pass_cnt++;
        wait_ticks(6);
        total_cnt++;
        if (pop_got() !== {1'b1, model(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1)})
            $display("FAIL frame_8n1: wrong or missing frame, want a5 flags 000");
        else pass_cnt++;
        idle_bits(1);
    endtask

    task automatic test_7e2();
        logic [11:0] g;
        got_q.delete();
        send_frame(8'h35, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, model(8'h35, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1)})
            $display("FAIL frame_7e2_ok: got %h want %h", g,
                     {1'b1, model(8'h35, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1)});
        else pass_cnt++;
        send_frame(8'h35, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, 8'h35, 3'b100})
            $display("FAIL frame_7e2_perr: got %h want %h", g, {1'b1, 8'h35, 3'b100});
        else pass_cnt++;
    endtask

    task automatic test_8o1_errors();
        logic [11:0] g;
        got_q.delete();
        send_frame(8'hFF, 1'b1, 2'b10, 1'b0, good_par(8'hFF, 1'b1, 2'b10), 1'b0, 1'b1);
        idle_bits(1);
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, 8'hFF, 3'b010})
            $display("FAIL frame_8o1_ferr: got %h want %h", g, {1'b1, 8'hFF, 3'b010});
        else pass_cnt++;
        send_frame(8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, model(8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1)})
            $display("FAIL frame_8o1_break: got %h want %h", g,
                     {1'b1, model(8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1)});
        else pass_cnt++;
    endtask

    task automatic test_long_break();
        logic [11:0] g;
        got_q.delete();
        align();
        #1;
        d_num = 1'b1;
        s_num = 1'b0;
        par = 2'b00;
        rx = 1'b0;
        wait_ticks(40 * Os - 1);
        idle_bits(2);
        total_cnt++;
        if (got_q.size() != 1) $display("FAIL break_count: got %0d frames want 1", got_q.size());
        else pass_cnt++;
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, model(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)})
            $display("FAIL break_frame: got %h want %h", g,
                     {1'b1, model(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0)});
        else pass_cnt++;
        send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, 8'h5A, 3'b000})
            $display("FAIL after_break: got %h want %h", g, {1'b1, 8'h5A, 3'b000});
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int rises = rise_cnt;
        align();
        #1 rx = 1'b0;
        wait_ticks(2);
        #1;
        total_cnt++;
        if (rx_busy !== 1'b1) $display("FAIL glitch_busy: got %b want 1", rx_busy);
        else pass_cnt++;
        wait_ticks(2);
        #1 rx = 1'b1;
        wait_ticks(8);
        #1;
        total_cnt++;
        if (rx_busy !== 1'b0) $display("FAIL glitch_idle: got %b want 0", rx_busy);
        else pass_cnt++;
        idle_bits(2);
        total_cnt++;
        if (rise_cnt != rises) $display("FAIL glitch_valid: got %0d rises want 0", rise_cnt - rises);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ovr0;
        logic [11:0] g;
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        ovr0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        total_cnt++;
        if ({rx_valid, data_out} !== {1'b1, 8'h11})
            $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=11", rx_valid, data_out);
        else pass_cnt++;
        total_cnt++;
        if (ovr_cnt - ovr0 != 1) $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - ovr0);
        else pass_cnt++;
        pulse_ready();
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, 8'h11, 3'b000})
            $display("FAIL ovr_consume: got %h want %h", g, {1'b1, 8'h11, 3'b000});
        else pass_cnt++;

        ovr0 = ovr_cnt;
        send_frame(8'h33, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_head(8'h44, 1'b1, 2'b00, 1'b0, 1'b0);
        align();
        #1 rx = 1'b1;
        wait_ticks(9);
        repeat (TickDiv - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        total_cnt++;
        if ({rx_valid, data_out} !== {1'b1, 8'h44})
            $display("FAIL ready_in_done: got v=%b d=%h want v=1 d=44", rx_valid, data_out);
        else pass_cnt++;
        wait_ticks(6);
        total_cnt++;
        if (ovr_cnt != ovr0) $display("FAIL ready_no_ovr: got %0d want 0", ovr_cnt - ovr0);
        else pass_cnt++;
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, 8'h33, 3'b000})
            $display("FAIL ready_consumed: got %h want %h", g, {1'b1, 8'h33, 3'b000});
        else pass_cnt++;
        pulse_ready();
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, 8'h44, 3'b000})
            $display("FAIL ready_second: got %h want %h", g, {1'b1, 8'h44, 3'b000});
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] c3 = 8'hC3;
        logic [11:0] g;
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        total_cnt++;
        if (rx_valid !== 1'b1) $display("FAIL rst_setup: got %b want 1", rx_valid);
        else pass_cnt++;
        align();
        #1 rx = 1'b0;
        wait_ticks(Os - 1);
        for (int i = 0; i < 3; i++) send_bit(c3[i]);
        align();
        #1 rx = c3[3];
        wait_ticks(8);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({data_out, rx_valid, parity_error, frame_error, break_det, overrun, rx_busy} !== 14'h0)
            $display("FAIL rst_mid: got d=%h v=%b busy=%b want all 0", data_out, rx_valid, rx_busy);
        else pass_cnt++;
        reset = 1'b0;
        rx = 1'b1;
        rx_ready = 1'b1;
        got_q.delete();
        idle_bits(2);
        send_frame(8'hC3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        g = pop_got();
        total_cnt++;
        if (g !== {1'b1, 8'hC3, 3'b000})
            $display("FAIL rst_after: got %h want %h", g, {1'b1, 8'hC3, 3'b000});
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] data;
        logic d8, s2, pbit, st0, st1;
        logic [1:0] p;
        logic [10:0] e;
        logic [11:0] g;
        rx_ready = 1'b1;
        got_q.delete();
        for (int n = 0; n < 20; n++) begin
            data = 8'($urandom);
            d8 = 1'($urandom);
            s2 = 1'($urandom);
            p = 2'($urandom);
            st0 = ($urandom_range(0, 3) != 0);
            st1 = ($urandom_range(0, 3) != 0);
            pbit = good_par(data, d8, p) ^ ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) data = 8'h00;
            e = model(data, d8, p, s2, pbit, st0, st1);
            send_frame(data, d8, p, s2, pbit, st0, st1);
            idle_bits(1);
            g = pop_got();
            total_cnt++;
            if (g !== {1'b1, e})
                $display("FAIL rand_%0d: got %h want %h (d=%h d8=%b p=%b s2=%b pb=%b st=%b%b)",
                         n, g, {1'b1, e}, data, d8, p, s2, pbit, st0, st1);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_8n1_latency();
        test_7e2();
        test_8o1_errors();
        test_long_break();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
